rx_frame_strip: RTL and testbench

- Receiver-side counterpart of the transmitter output stage.
- Takes the received 12-bit I/Q sample stream plus a start-of-frame pulse from the upstream timing-sync block.
- Discards the preamble, then strips the cyclic prefix from each OFDM symbol and forwards only the N useful samples per symbol, with symbol markers, to the receiver FFT.
- Sits between timing sync and the RX FFT.

---
 rtl/rx_pkg.sv | 32 +++
 rtl/rx_seg_counter.sv | 34 +++
 rtl/rx_frame_strip.sv | 167 ++++++++++++++++
 tb/tb_rx_frame_strip.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and sizing helpers for the receive-side frame strip path.
// Defaults mirror the transmitter's frame geometry.
package rx_pkg;

    localparam int N_DEF       = 64;
    localparam int CP_LEN_DEF  = 16;
    localparam int PRB_NUM_DEF = 2;
    localparam int MAX_SYM_DEF = 128;
    localparam int DW_DEF      = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRB  = 2'd1,
        CP   = 2'd2,
        DATA = 2'd3
    } rx_state_t;

    function automatic int prb_len(input int n, input int prb_num);
        return n * prb_num;
    endfunction

    // Wide enough for the longest segment; the terminal counts stay below it.
    function automatic int cnt_width(input int prb_l, input int n, input int cp);
        int m;
        m = prb_l;
        if (n > m) m = n;
        if (cp > m) m = cp;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/rx_seg_counter.sv
// Segment counter: counts enabled cycles up to a per-segment terminal value,
// then wraps to zero. Load and clear override counting.
module rx_seg_counter #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    input  logic [CW-1:0] i_terminal,
    output logic [CW-1:0] o_count,
    output logic          o_last
);

    logic [CW-1:0] r_count;

    assign o_count = r_count;
    assign o_last  = (r_count == i_terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= o_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_strip.sv
// Receive frame strip: drops the preamble and each symbol's cyclic prefix,
// forwarding only the useful samples with symbol markers to the RX FFT.
module rx_frame_strip
    import rx_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int CP_LEN  = CP_LEN_DEF,
    parameter int PRB_NUM = PRB_NUM_DEF,
    parameter int MAX_SYM = MAX_SYM_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_new_frame,
    input  logic          i_sof,
    input  logic [7:0]    i_num_sym,
    input  logic [DW-1:0] i_di_re,
    input  logic [DW-1:0] i_di_im,
    input  logic          i_di_vld,
    output logic [DW-1:0] o_do_re,
    output logic [DW-1:0] o_do_im,
    output logic          o_do_vld,
    output logic          o_do_sos,
    output logic          o_do_eos,
    output logic [7:0]    o_sym_idx,
    output logic          o_frame_done,
    output logic          o_busy,
    output logic          o_err_resync
);

    localparam int PRB_LEN = prb_len(N, PRB_NUM);
    localparam int CW      = cnt_width(PRB_LEN, N, CP_LEN);

    localparam logic [CW-1:0] PRB_LAST = CW'(PRB_LEN - 1);
    localparam logic [CW-1:0] CP_LAST  = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] N_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [7:0]    MAX_SYM8 = 8'(MAX_SYM);

    rx_state_t     r_state;
    logic [7:0]    r_nsym;
    logic [7:0]    r_sym;

    logic          w_start;
    logic          w_cnt_en;
    logic          w_cnt_last;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_terminal;
    logic [7:0]    w_nsym_clamped;
    logic          w_last_sym;

    // The sof sample itself is preamble sample 0, so a restart loads 1.
    assign w_start        = i_sof & i_di_vld;
    assign w_cnt_en       = i_di_vld & (r_state != IDLE);
    assign w_nsym_clamped = (i_num_sym > MAX_SYM8) ? MAX_SYM8 : i_num_sym;
    assign w_last_sym     = (r_sym == r_nsym - 8'd1);

    always_comb begin
        w_terminal = PRB_LAST;
        unique case (r_state)
            PRB:     w_terminal = PRB_LAST;
            CP:      w_terminal = CP_LAST;
            DATA:    w_terminal = N_LAST;
            default: w_terminal = PRB_LAST;
        endcase
    end

    rx_seg_counter #(
        .CW(CW)
    ) u_seg_counter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (i_new_frame),
        .i_load     (w_start),
        .i_load_val (CNT_ONE),
        .i_en       (w_cnt_en),
        .i_terminal (w_terminal),
        .o_count    (w_cnt),
        .o_last     (w_cnt_last)
    );

    // busy trails the state by one cycle so it drops after the frame_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_nsym       <= '0;
            r_sym        <= '0;
            o_do_re      <= '0;
            o_do_im      <= '0;
            o_do_vld     <= 1'b0;
            o_do_sos     <= 1'b0;
            o_do_eos     <= 1'b0;
            o_sym_idx    <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_err_resync <= 1'b0;
        end else if (i_new_frame) begin
            r_state      <= IDLE;
            r_nsym       <= '0;
            r_sym        <= '0;
            o_do_re      <= '0;
            o_do_im      <= '0;
            o_do_vld     <= 1'b0;
            o_do_sos     <= 1'b0;
            o_do_eos     <= 1'b0;
            o_sym_idx    <= '0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_err_resync <= 1'b0;
        end else begin
            o_do_re      <= '0;
            o_do_im      <= '0;
            o_do_vld     <= 1'b0;
            o_do_sos     <= 1'b0;
            o_do_eos     <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_resync <= 1'b0;
            o_busy       <= (r_state != IDLE);
            o_sym_idx    <= r_sym;

            if (w_start) begin
                r_state      <= PRB;
                r_nsym       <= w_nsym_clamped;
                r_sym        <= '0;
                o_err_resync <= (r_state != IDLE);
            end else if (i_di_vld) begin
                case (r_state)
                    PRB: begin
                        if (w_cnt_last) begin
                            if (r_nsym == 8'd0) begin
                                r_state      <= IDLE;
                                o_frame_done <= 1'b1;
                            end else begin
                                r_state <= CP;
                            end
                        end
                    end
                    CP: begin
                        if (w_cnt_last) begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        o_do_vld <= 1'b1;
                        o_do_re  <= i_di_re;
                        o_do_im  <= i_di_im;
                        o_do_sos <= (w_cnt == '0);
                        o_do_eos <= w_cnt_last;
                        if (w_cnt_last) begin
                            if (w_last_sym) begin
                                r_state      <= IDLE;
                                r_sym        <= '0;
                                o_frame_done <= 1'b1;
                            end else begin
                                r_state <= CP;
                                r_sym   <= r_sym + 8'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_strip.sv
// Self-checking bench for rx_frame_strip: table vectors, directed frames and
// randomized traffic against a position-based frame model.
module tb_rx_frame_strip;

    localparam int N       = 64;
    localparam int CP_LEN  = 16;
    localparam int PRB_LEN = 128;
    localparam int SYM_LEN = N + CP_LEN;

    logic        clk = 1'b0;
    logic        reset;
    logic        newFrame;
    logic        sof;
    logic [7:0]  numSym;
    logic [11:0] diRe;
    logic [11:0] diIm;
    logic        diVld;
    logic [11:0] doRe;
    logic [11:0] doIm;
    logic        doVld;
    logic        doSos;
    logic        doEos;
    logic [7:0]  symIdx;
    logic        frameDone;
    logic        busy;
    logic        errResync;

    int numVectors = 0;
    int numMiscompares = 0;
    string curTest = "init";

    // Reference model state: active frame, next sample position, symbol count.
    bit mActive = 0;
    int mPos = 0;
    int mNsym = 0;

    int tVld, tEos, tErr, tFirstSos, tLastEos, tLastEosSym, tDone;
    int tSosAfterErr, tSymAfterErr;
    bit tSeenErr;

    typedef struct {
        logic       vld;
        logic       sof;
        logic [7:0] ns;
        logic       eVld;
        logic       eBusy;
        logic       eErr;
        logic       eDone;
    } tblVec_t;

    tblVec_t tbl[7];

    rx_frame_strip dut (
        .clk          (clk),
        .reset        (reset),
        .i_new_frame  (newFrame),
        .i_sof        (sof),
        .i_num_sym    (numSym),
        .i_di_re      (diRe),
        .i_di_im      (diIm),
        .i_di_vld     (diVld),
        .o_do_re      (doRe),
        .o_do_im      (doIm),
        .o_do_vld     (doVld),
        .o_do_sos     (doSos),
        .o_do_eos     (doEos),
        .o_sym_idx    (symIdx),
        .o_frame_done (frameDone),
        .o_busy       (busy),
        .o_err_resync (errResync)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [11:0] eRe, input logic [11:0] eIm,
                               input logic eVld, input logic eSos, input logic eEos,
                               input logic eDone, input logic eErr, input logic eBusy,
                               input logic [7:0] eSym, input bit cmpSym);
        bit bad;
        bad = (doVld !== eVld) || (doSos !== eSos) || (doEos !== eEos) || (frameDone !== eDone) ||
              (errResync !== eErr) || (busy !== eBusy) || (doRe !== eRe) || (doIm !== eIm) ||
              (cmpSym && (symIdx !== eSym));
        numVectors++;
        if (bad) begin
            numMiscompares++;
            $display("[TB] FAIL %s t=%0t: got vld=%b sos=%b eos=%b done=%b err=%b busy=%b re=%0d im=%0d sym=%0d, expected vld=%b sos=%b eos=%b done=%b err=%b busy=%b re=%0d im=%0d sym=%0d",
                     name, $time, doVld, doSos, doEos, frameDone, errResync, busy, doRe, doIm, symIdx,
                     eVld, eSos, eEos, eDone, eErr, eBusy, eRe, eIm, eSym);
        end
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        numVectors++;
        if (actual != expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearTallies();
        tVld = 0; tEos = 0; tErr = 0; tFirstSos = -1; tLastEos = -1; tLastEosSym = -1;
        tDone = -1; tSosAfterErr = -1; tSymAfterErr = -1; tSeenErr = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic nf, input logic [7:0] ns,
                                 input logic [11:0] re, input logic [11:0] im, input int idx);
        logic [11:0] eRe, eIm;
        logic eVld, eSos, eEos, eDone, eErr, eBusy;
        logic [7:0] eSym;
        int p, q, sym, off;
        diVld = v; sof = s; newFrame = nf; numSym = ns; diRe = re; diIm = im;
        eRe = '0; eIm = '0; eVld = 0; eSos = 0; eEos = 0; eDone = 0; eErr = 0; eBusy = 0; eSym = '0;
        if (nf) begin
            mActive = 0;
        end else begin
            eBusy = mActive;
            if (v && s) begin
                eErr = mActive;
                mActive = 1;
                mPos = 1;
                mNsym = (int'(ns) > 128) ? 128 : int'(ns);
            end else if (v && mActive) begin
                p = mPos;
                mPos++;
                if (p == PRB_LEN - 1 && mNsym == 0) begin
                    eDone = 1;
                    mActive = 0;
                end else if (p >= PRB_LEN) begin
                    q = p - PRB_LEN;
                    sym = q / SYM_LEN;
                    off = q % SYM_LEN;
                    if (off >= CP_LEN) begin
                        eVld = 1; eRe = re; eIm = im;
                        eSos = (off == CP_LEN);
                        eEos = (off == SYM_LEN - 1);
                        eSym = 8'(sym);
                        if (eEos && sym == mNsym - 1) begin
                            eDone = 1;
                            mActive = 0;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput(curTest, eRe, eIm, eVld, eSos, eEos, eDone, eErr, eBusy, eSym, eVld);
        if (doVld === 1'b1) tVld++;
        if (doSos === 1'b1) begin
            if (tFirstSos < 0) tFirstSos = idx;
            if (tSeenErr && tSosAfterErr < 0) begin
                tSosAfterErr = idx;
                tSymAfterErr = int'(symIdx);
            end
        end
        if (doEos === 1'b1) begin
            tEos++;
            tLastEos = idx;
            tLastEosSym = int'(symIdx);
        end
        if (frameDone === 1'b1) tDone = idx;
        if (errResync === 1'b1) begin
            tErr++;
            tSeenErr = 1;
        end
        @(negedge clk);
    endtask

    task automatic runFrame(input logic [7:0] ns, input int nSamples, input bit gap, input int resyncAt);
        for (int i = 0; i < nSamples; i++) begin
            if (gap) applyStimulus(1'b0, 1'b0, 1'b0, ns, 12'($urandom), 12'($urandom), -1);
            applyStimulus(1'b1, (i == 0) || (i == resyncAt), 1'b0, ns, 12'(i), 12'(-i), i);
        end
    endtask

    initial begin
        reset = 1'b1; newFrame = 1'b0; sof = 1'b0; numSym = '0;
        diRe = '0; diIm = '0; diVld = 1'b0;
        clearTallies();
        #1;
        checkOutput("reset_state", '0, '0, 0, 0, 0, 0, 0, 0, '0, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // IDLE drops, sof without valid, lagging busy, resync out of PRB.
        tbl[0] = '{vld:1, sof:0, ns:8'd3, eVld:0, eBusy:0, eErr:0, eDone:0};
        tbl[1] = '{vld:0, sof:1, ns:8'd3, eVld:0, eBusy:0, eErr:0, eDone:0};
        tbl[2] = '{vld:1, sof:1, ns:8'd3, eVld:0, eBusy:0, eErr:0, eDone:0};
        tbl[3] = '{vld:1, sof:0, ns:8'd3, eVld:0, eBusy:1, eErr:0, eDone:0};
        tbl[4] = '{vld:0, sof:0, ns:8'd3, eVld:0, eBusy:1, eErr:0, eDone:0};
        tbl[5] = '{vld:1, sof:1, ns:8'd3, eVld:0, eBusy:1, eErr:1, eDone:0};
        tbl[6] = '{vld:1, sof:0, ns:8'd3, eVld:0, eBusy:1, eErr:0, eDone:0};
        for (int i = 0; i < 7; i++) begin
            diVld = tbl[i].vld; sof = tbl[i].sof; numSym = tbl[i].ns;
            diRe = 12'($urandom); diIm = 12'($urandom);
            @(posedge clk);
            #1;
            checkOutput($sformatf("table_%0d", i), '0, '0, tbl[i].eVld, 0, 0, tbl[i].eDone,
                        tbl[i].eErr, tbl[i].eBusy, '0, 0);
            @(negedge clk);
        end
        curTest = "new_frame_after_table";
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 12'd5, 12'd5, 0);

        curTest = "continuous_3sym";
        clearTallies();
        runFrame(8'd3, 380, 0, -1);
        checkValue("cont_vld_count", tVld, 192);
        checkValue("cont_first_sos", tFirstSos, 144);
        checkValue("cont_last_eos", tLastEos, 367);
        checkValue("cont_last_sym", tLastEosSym, 2);
        checkValue("cont_done_idx", tDone, 367);
        checkValue("cont_eos_count", tEos, 3);

        curTest = "gapped_3sym";
        clearTallies();
        runFrame(8'd3, 380, 1, -1);
        checkValue("gap_vld_count", tVld, 192);
        checkValue("gap_first_sos", tFirstSos, 144);
        checkValue("gap_last_eos", tLastEos, 367);
        checkValue("gap_done_idx", tDone, 367);

        curTest = "zero_sym";
        clearTallies();
        runFrame(8'd0, 140, 0, -1);
        checkValue("zero_vld_count", tVld, 0);
        checkValue("zero_done_idx", tDone, 127);

        curTest = "clamp_200";
        clearTallies();
        runFrame(8'd200, 10380, 0, -1);
        checkValue("clamp_vld_count", tVld, 128 * 64);
        checkValue("clamp_last_eos", tLastEos, 10367);
        checkValue("clamp_last_sym", tLastEosSym, 127);
        checkValue("clamp_done_idx", tDone, 10367);

        curTest = "resync_250";
        clearTallies();
        runFrame(8'd3, 500, 0, 250);
        checkValue("resync_err_count", tErr, 1);
        checkValue("resync_next_sos", tSosAfterErr, 394);
        checkValue("resync_next_sym", tSymAfterErr, 0);
        checkValue("resync_eos_count", tEos, 2);

        curTest = "random";
        clearTallies();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 12'($urandom), 12'($urandom), 0);
        for (int i = 0; i < 4000; i++) begin
            logic v, s, nf;
            logic [7:0] ns;
            v  = ($urandom_range(0, 9) < 7);
            s  = ($urandom_range(0, 699) == 0) || ($urandom_range(0, 199) == 0 && !v);
            nf = ($urandom_range(0, 1499) == 0);
            ns = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(129, 255)) : 8'($urandom_range(0, 3));
            applyStimulus(v, s, nf, ns, 12'($urandom), 12'($urandom), i);
        end

        curTest = "reset_mid_data";
        clearTallies();
        runFrame(8'd3, 170, 0, -1);
        reset = 1'b1;
        #1;
        checkOutput("reset_async_outputs", '0, '0, 0, 0, 0, 0, 0, 0, '0, 1);
        mActive = 0;
        @(negedge clk);
        reset = 1'b0;
        clearTallies();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 12'(i), 12'(-i), i);
        checkValue("after_reset_vld", tVld, 0);

        curTest = "new_frame_mid_prb";
        clearTallies();
        runFrame(8'd2, 50, 0, -1);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 12'd50, 12'd77, 50);
        checkOutput("new_frame_outputs", '0, '0, 0, 0, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 12'(i), 12'(-i), i);
        checkValue("after_new_frame_vld", tVld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
